// File: rtl/imem_fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch controller and the memory.
// Single outstanding request: req/addr handshake with gnt, then one rvalid/rdata beat.
interface imem_fetch_ctrl_if #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned InstrWidth = 32
);
  logic                  imem_req_o;
  logic [DataWidth-1:0]  imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [InstrWidth-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, stall hold and EX-stage redirect.
// A redirect that overtakes an in-flight request marks exactly one response for discard.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_f,
  input  logic                pc_src_e,
  input  logic [31:0]         pc_target_e,
  imem_fetch_ctrl_if.master   imem,
  output logic                instr_valid_o,
  output logic [31:0]         instr_f_o,
  output logic [31:0]         pc_f_o,
  output logic [31:0]         pc_plus_4_f_o,
  output logic                fetch_busy_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        discard_q, discard_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    discard_d = discard_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (pc_src_e) pc_d = pc_target_e;
        if (imem.imem_gnt_i) begin
          state_d   = StWait;
          discard_d = pc_src_e;
        end
      end
      StWait: begin
        if (pc_src_e) pc_d = pc_target_e;
        if (imem.imem_rvalid_i) begin
          // Stale response: drop it and refetch from whatever pc now holds.
          if (pc_src_e || discard_q) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            instr_d = imem.imem_rdata_i;
            state_d = StHold;
          end
        end else if (pc_src_e) begin
          discard_d = 1'b1;
        end
      end
      StHold: begin
        if (pc_src_e) begin
          pc_d    = pc_target_e;
          state_d = StReq;
        end else if (!stall_f) begin
          pc_d    = pc_q + 32'd4;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
    req_d   = (state_d == StReq);
    valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      discard_q <= discard_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = pc_q;
  assign instr_valid_o    = valid_q;
  assign instr_f_o        = instr_q;
  assign pc_f_o           = pc_q;
  assign pc_plus_4_f_o    = pc_q + 32'd4;
  assign fetch_busy_o     = !valid_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: per-cycle vector table plus hand-written redirect,
// stall, wrap and reset-in-flight sequences.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        instr_valid_o;
  logic [31:0] instr_f_o;
  logic [31:0] pc_f_o;
  logic [31:0] pc_plus_4_f_o;
  logic        fetch_busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] Junk = 32'hDEAD_BEEF;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_f       (stall_f),
    .pc_src_e      (pc_src_e),
    .pc_target_e   (pc_target_e),
    .imem          (bus.master),
    .instr_valid_o (instr_valid_o),
    .instr_f_o     (instr_f_o),
    .pc_f_o        (pc_f_o),
    .pc_plus_4_f_o (pc_plus_4_f_o),
    .fetch_busy_o  (fetch_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        src;
    logic [31:0] tgt;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs apply to the next posedge; expectations describe outputs just after it.
  task automatic step(input string nm, input logic rst, input logic stall, input logic src,
                      input logic [31:0] tgt, input logic gnt, input logic rv,
                      input logic [31:0] rd, input logic e_req, input logic [31:0] e_pc,
                      input logic e_v, input logic [31:0] e_instr);
    rst_n             = rst;
    stall_f           = stall;
    pc_src_e          = src;
    pc_target_e       = tgt;
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rd;
    @(posedge clk);
    #1;
    chk({nm, "/req"}, {31'b0, bus.imem_req_o}, {31'b0, e_req});
    chk({nm, "/addr"}, bus.imem_addr_o, e_pc);
    chk({nm, "/pc"}, pc_f_o, e_pc);
    chk({nm, "/pc4"}, pc_plus_4_f_o, e_pc + 32'd4);
    chk({nm, "/valid"}, {31'b0, instr_valid_o}, {31'b0, e_v});
    chk({nm, "/busy"}, {31'b0, fetch_busy_o}, {31'b0, !e_v});
    if (e_v || !rst) chk({nm, "/instr"}, instr_f_o, e_instr);
  endtask

  initial begin
    // rst stall src tgt gnt rv rdata | req pc valid instr
    vecs[0]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[2]  = '{1, 0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h0,   0, 32'h0};
    vecs[3]  = '{1, 0, 0, 32'h0,   1, 0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[4]  = '{1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[5]  = '{1, 0, 0, 32'h0,   0, 1, 32'h0010_0093, 0, 32'h0,   1, 32'h0010_0093};
    vecs[6]  = '{1, 1, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   1, 32'h0010_0093};
    vecs[7]  = '{1, 1, 0, 32'h0,   1, 0, 32'h0,        0, 32'h0,   1, 32'h0010_0093};
    vecs[8]  = '{1, 1, 0, 32'h0,   0, 1, Junk,         0, 32'h0,   1, 32'h0010_0093};
    vecs[9]  = '{1, 1, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   1, 32'h0010_0093};
    vecs[10] = '{1, 1, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   1, 32'h0010_0093};
    vecs[11] = '{1, 0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h4,   0, 32'h0};
    vecs[12] = '{1, 0, 0, 32'h0,   1, 0, 32'h0,        0, 32'h4,   0, 32'h0};
    vecs[13] = '{1, 0, 1, 32'h100, 0, 0, 32'h0,        0, 32'h100, 0, 32'h0};
    vecs[14] = '{1, 0, 0, 32'h0,   0, 1, Junk,         1, 32'h100, 0, 32'h0};
    vecs[15] = '{1, 0, 0, 32'h0,   1, 0, 32'h0,        0, 32'h100, 0, 32'h0};
    vecs[16] = '{1, 0, 0, 32'h0,   0, 1, 32'h0020_0113, 0, 32'h100, 1, 32'h0020_0113};
    vecs[17] = '{1, 0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h104, 0, 32'h0};

    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].stall, vecs[i].src, vecs[i].tgt,
           vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].e_req, vecs[i].e_pc,
           vecs[i].e_valid, vecs[i].e_instr);
    end

    // Redirect coincident with grant: that response is dropped.
    step("redir_gnt0", 1, 0, 1, 32'h200, 1, 0, 32'h0, 0, 32'h200, 0, 32'h0);
    step("redir_gnt1", 1, 0, 0, 32'h0,   0, 1, Junk,  1, 32'h200, 0, 32'h0);
    step("redir_gnt2", 1, 0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h200, 0, 32'h0);
    step("redir_gnt3", 1, 0, 0, 32'h0,   0, 1, 32'h0030_0193, 0, 32'h200, 1, 32'h0030_0193);

    // Redirect coincident with rvalid.
    step("redir_rv0", 1, 0, 0, 32'h0,   0, 0, 32'h0, 1, 32'h204, 0, 32'h0);
    step("redir_rv1", 1, 0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h204, 0, 32'h0);
    step("redir_rv2", 1, 0, 1, 32'h300, 0, 1, Junk,  1, 32'h300, 0, 32'h0);
    step("redir_rv3", 1, 0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h300, 0, 32'h0);
    step("redir_rv4", 1, 0, 0, 32'h0,   0, 1, 32'h0040_0213, 0, 32'h300, 1, 32'h0040_0213);

    // Grant withheld, then redirected while still requesting.
    step("nognt0", 1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h304, 0, 32'h0);
    for (int i = 0; i < 4; i++)
      step($sformatf("nognt_hold%0d", i), 1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h304, 0, 32'h0);
    step("nognt_redir", 1, 0, 1, 32'h400, 0, 0, 32'h0, 1, 32'h400, 0, 32'h0);
    step("nognt_gnt",   1, 0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h400, 0, 32'h0);
    step("nognt_rv",    1, 0, 0, 32'h0,   0, 1, 32'h0050_0293, 0, 32'h400, 1, 32'h0050_0293);

    // Two redirects while one response is outstanding: exactly one drop.
    step("dbl0", 1, 0, 0, 32'h0,   0, 0, 32'h0, 1, 32'h404, 0, 32'h0);
    step("dbl1", 1, 0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h404, 0, 32'h0);
    step("dbl2", 1, 0, 1, 32'h500, 0, 0, 32'h0, 0, 32'h500, 0, 32'h0);
    step("dbl3", 1, 0, 1, 32'h600, 0, 0, 32'h0, 0, 32'h600, 0, 32'h0);
    step("dbl4", 1, 0, 0, 32'h0,   0, 1, Junk,  1, 32'h600, 0, 32'h0);
    step("dbl5", 1, 0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h600, 0, 32'h0);
    step("dbl6", 1, 0, 0, 32'h0,   0, 1, 32'h0060_0313, 0, 32'h600, 1, 32'h0060_0313);

    // Redirect beats stall in HOLD; unaligned-free target near the top wraps to 0.
    step("wrap0", 1, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    step("wrap1", 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'hFFFF_FFFC, 0, 32'h0);
    step("wrap2", 1, 0, 0, 32'h0, 0, 1, 32'h0070_0393, 0, 32'hFFFF_FFFC, 1, 32'h0070_0393);
    step("wrap3", 1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0);

    // Reset while a response is in flight; late rvalid must be ignored.
    step("rst0", 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step("rst1", 1, 0, 0, 32'h0, 0, 1, 32'h0080_0413, 0, 32'h0, 1, 32'h0080_0413);
    step("rst2", 1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h4, 0, 32'h0);
    step("rst3", 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h4, 0, 32'h0);
    step("rst4", 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step("rst5", 1, 0, 0, 32'h0, 0, 1, Junk,  1, 32'h0, 0, 32'h0);
    step("rst6", 1, 0, 0, 32'h0, 0, 1, Junk,  1, 32'h0, 0, 32'h0);
    step("rst7", 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step("rst8", 1, 0, 0, 32'h0, 0, 1, 32'h0090_0493, 0, 32'h0, 1, 32'h0090_0493);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
